axis_pack2: RTL and testbench

Width upsizer for the project's AXI-Stream test template. It accepts a stream of nb-bit beats and packs consecutive pairs into 2·nb-bit beats; the first beat goes in the low half. It is the inverse-direction counterpart of the 2·nb→nb stream stage: it sits on the data path where a narrow producer feeds a wide consumer. A packet ending on an odd beat is flushed as a half-filled word, flagged by tkeep.

---
 rtl/axis_pack2_if.sv | 25 ++
 rtl/axis_pack2.sv | 86 ++++++++
 tb/tb_axis_pack2.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pack2_if.sv
// Stream bundle for the 2:1 width upsizer: narrow input side, wide output side.
// The slave view is the packer itself; the master view is the producer/consumer pair around it.
interface axis_pack2_if #(
  parameter int nb = 40
) ();
  logic [nb-1:0]   in_tdata;
  logic            in_tvalid;
  logic            in_tlast;
  logic            in_tready;
  logic [2*nb-1:0] out_tdata;
  logic [1:0]      out_tkeep;
  logic            out_tlast;
  logic            out_tvalid;
  logic            out_tready;

  modport slave (
    input  in_tdata, in_tvalid, in_tlast, out_tready,
    output in_tready, out_tdata, out_tkeep, out_tlast, out_tvalid
  );

  modport master (
    output in_tdata, in_tvalid, in_tlast, out_tready,
    input  in_tready, out_tdata, out_tkeep, out_tlast, out_tvalid
  );
endinterface

// File: rtl/axis_pack2.sv
// Packs pairs of nb-bit stream beats into 2*nb-bit words, first beat in the low half.
// A packet ending on an odd beat is flushed as a half word with tkeep=2'b01.
//   state   | meaning
//   EMPTY   | no low half held; next accepted beat is a low half
//   HAVE_LO | lo holds the first beat of a pair
module axis_pack2 #(
  parameter  int n  = 5,
  localparam int nb = n * 8
) (
  input logic          clk,
  input logic          reset,
  axis_pack2_if.slave  s
);

  typedef enum logic {EMPTY, HAVE_LO} state_t;

  state_t          state, state_nxt;
  logic [nb-1:0]   lo, lo_nxt;
  logic [2*nb-1:0] data_q, data_nxt;
  logic [1:0]      keep_q, keep_nxt;
  logic            last_q, last_nxt;
  logic            valid_q, valid_nxt;
  logic            ready;
  logic            accept;

  assign ready  = ~reset & (~valid_q | s.out_tready);
  assign accept = s.in_tvalid & ready;

  assign s.in_tready  = ready;
  assign s.out_tdata  = data_q;
  assign s.out_tkeep  = keep_q;
  assign s.out_tlast  = last_q;
  assign s.out_tvalid = valid_q;

  always_comb begin
    state_nxt = state;
    lo_nxt    = lo;
    data_nxt  = data_q;
    keep_nxt  = keep_q;
    last_nxt  = last_q;
    // drain clears valid; a load below overrides it
    valid_nxt = valid_q & ~s.out_tready;
    if (accept) begin
      case (state)
        EMPTY: begin
          if (s.in_tlast) begin
            data_nxt  = {{nb{1'b0}}, s.in_tdata};
            keep_nxt  = 2'b01;
            last_nxt  = 1'b1;
            valid_nxt = 1'b1;
          end else begin
            lo_nxt    = s.in_tdata;
            state_nxt = HAVE_LO;
          end
        end
        HAVE_LO: begin
          data_nxt  = {s.in_tdata, lo};
          keep_nxt  = 2'b11;
          last_nxt  = s.in_tlast;
          valid_nxt = 1'b1;
          state_nxt = EMPTY;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      lo      <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      lo      <= lo_nxt;
      data_q  <= data_nxt;
      keep_q  <= keep_nxt;
      last_q  <= last_nxt;
      valid_q <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_axis_pack2.sv
// Directed bench for axis_pack2: a beat-queue packing model checked on every cycle,
// plus literal expectations for each scenario's received words.
module tb_axis_pack2;
  localparam int N  = 5;
  localparam int NB = N * 8;

  typedef struct packed {
    logic            last;
    logic [1:0]      keep;
    logic [2*NB-1:0] data;
  } word_t;

  typedef struct {
    word_t w;
    int    cyc;
  } rx_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   stalls = 0;

  axis_pack2_if #(.nb(NB)) bus ();

  axis_pack2 #(.n(N)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus)
  );

  always #5 clk = ~clk;

  logic [NB-1:0] pend[$];
  word_t         expq[$];
  rx_t           rx[$];
  logic          exp_next = 1'b0;
  logic          hold_prev = 1'b0;
  logic [2*NB+3:0] prev_out, cur_out;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: accepted beats collect per packet; a pair or a tlast beat yields one word.
  always @(negedge clk) begin
    word_t w;
    cyc++;
    if (reset) begin
      pend.delete();
      expq.delete();
      exp_next  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      cur_out = {bus.out_tvalid, bus.out_tlast, bus.out_tkeep, bus.out_tdata};
      if (hold_prev) chk("hold_stable", cur_out, prev_out);
      if (exp_next) begin
        chk("latency_valid", bus.out_tvalid, 1'b1);
        exp_next = 1'b0;
      end
      if (bus.out_tvalid && !bus.out_tready) chk("bp_in_tready", bus.in_tready, 1'b0);
      if (bus.out_tvalid && bus.out_tready) begin
        w = '{last: bus.out_tlast, keep: bus.out_tkeep, data: bus.out_tdata};
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected none", w);
        end else begin
          chk("model_word", w, expq.pop_front());
        end
        rx.push_back('{w: w, cyc: cyc});
      end
      hold_prev = bus.out_tvalid & ~bus.out_tready;
      prev_out  = cur_out;
      if (bus.in_tvalid && bus.in_tready) begin
        pend.push_back(bus.in_tdata);
        if (pend.size() == 2) begin
          expq.push_back('{last: bus.in_tlast, keep: 2'b11, data: {pend[1], pend[0]}});
          pend.delete();
          exp_next = 1'b1;
        end else if (bus.in_tlast) begin
          expq.push_back('{last: 1'b1, keep: 2'b01, data: {{NB{1'b0}}, pend[0]}});
          pend.delete();
          exp_next = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [NB-1:0] d, input logic l);
    int k = 0;
    bus.in_tdata  = d;
    bus.in_tlast  = l;
    bus.in_tvalid = 1'b1;
    @(negedge clk);
    if (!bus.in_tready) stalls++;
    while (!bus.in_tready && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (!bus.in_tready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_tready=0 expected 1 for beat %0h", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    bus.in_tvalid = 1'b0;
    bus.in_tlast  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk_rx(input string nm, input int idx, input logic [NB-1:0] hi,
                        input logic [NB-1:0] lo_h, input logic [1:0] keep, input logic last);
    if (idx >= rx.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: got %0d words expected index %0d", nm, rx.size(), idx);
    end else begin
      chk(nm, rx[idx].w, {last, keep, hi, lo_h});
    end
  endtask

  initial begin
    bus.in_tdata   = '0;
    bus.in_tvalid  = 1'b0;
    bus.in_tlast   = 1'b0;
    bus.out_tready = 1'b1;

    // reset held with in_tvalid asserted
    reset = 1'b1;
    bus.in_tvalid = 1'b1;
    bus.in_tdata  = 40'h99;
    repeat (3) begin
      @(negedge clk);
      chk("reset_in_tready", bus.in_tready, 1'b0);
      chk("reset_outputs", {bus.out_tvalid, bus.out_tlast, bus.out_tkeep, bus.out_tdata}, '0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_tvalid = 1'b0;

    // streaming
    rx.delete();
    stalls = 0;
    send(40'h01, 1'b0);
    send(40'h02, 1'b0);
    send(40'h03, 1'b0);
    send(40'h04, 1'b1);
    idle(4);
    chk("stream_no_stall", stalls, 0);
    chk("stream_count", rx.size(), 2);
    chk_rx("stream_w0", 0, 40'h02, 40'h01, 2'b11, 1'b0);
    chk_rx("stream_w1", 1, 40'h04, 40'h03, 2'b11, 1'b1);

    // odd packet then even packet
    rx.delete();
    send(40'hA, 1'b0);
    send(40'hB, 1'b0);
    send(40'hC, 1'b1);
    send(40'hD, 1'b0);
    send(40'hE, 1'b1);
    idle(4);
    chk("odd_count", rx.size(), 3);
    chk_rx("odd_w0", 0, 40'hB, 40'hA, 2'b11, 1'b0);
    chk_rx("odd_w1", 1, 40'h0, 40'hC, 2'b01, 1'b1);
    chk_rx("odd_w2", 2, 40'hE, 40'hD, 2'b11, 1'b1);

    // backpressure
    rx.delete();
    bus.out_tready = 1'b0;
    send(40'h21, 1'b0);
    send(40'h22, 1'b0);
    bus.in_tdata  = 40'h23;
    bus.in_tlast  = 1'b0;
    bus.in_tvalid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_stall_ready", bus.in_tready, 1'b0);
      chk("bp_held_word", {bus.out_tvalid, bus.out_tlast, bus.out_tkeep, bus.out_tdata},
          {1'b1, 1'b0, 2'b11, 40'h22, 40'h21});
    end
    @(posedge clk);
    #1;
    bus.out_tready = 1'b1;
    send(40'h23, 1'b0);
    send(40'h24, 1'b1);
    idle(4);
    chk("bp_count", rx.size(), 2);
    chk_rx("bp_w0", 0, 40'h22, 40'h21, 2'b11, 1'b0);
    chk_rx("bp_w1", 1, 40'h24, 40'h23, 2'b11, 1'b1);

    // reset while a low half is held
    rx.delete();
    send(40'h11, 1'b0);
    bus.in_tvalid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(40'h22, 1'b0);
    send(40'h33, 1'b1);
    idle(4);
    chk("rst_count", rx.size(), 1);
    chk_rx("rst_w0", 0, 40'h33, 40'h22, 2'b11, 1'b1);

    // back-to-back single-beat packets
    rx.delete();
    send(40'h5, 1'b1);
    send(40'h6, 1'b1);
    send(40'h7, 1'b1);
    idle(4);
    chk("single_count", rx.size(), 3);
    chk_rx("single_w0", 0, 40'h0, 40'h5, 2'b01, 1'b1);
    chk_rx("single_w1", 1, 40'h0, 40'h6, 2'b01, 1'b1);
    chk_rx("single_w2", 2, 40'h0, 40'h7, 2'b01, 1'b1);
    if (rx.size() == 3) begin
      chk("single_consec1", rx[1].cyc - rx[0].cyc, 1);
      chk("single_consec2", rx[2].cyc - rx[1].cyc, 1);
    end

    chk("model_drained", expq.size(), 0);
    chk("model_no_pending", pend.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
